// File: rtl/ml_acc_pkg.sv
// Shared types and constants for the ml_acc_system convolution path.
// No logic: widths, sequencer states, saturation bounds, register map.
// Consumers pick their own parameters; these are the system defaults.
package ml_acc_pkg;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;

  // Wide enough that summing 2^LEN_W full-scale products never wraps.
  function automatic int calc_acc_w(input int dw, input int lw);
    return 2 * dw + lw;
  endfunction

  localparam int ACC_W = calc_acc_w(DATA_W, LEN_W);

  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // AXI-lite register file seen by the PS.
  localparam logic [31:0] REG_BASE   = 32'h43C0_0000;
  localparam logic [7:0]  REG_RESULT = 8'h00;
  localparam logic [7:0]  REG_STATUS = 8'h04;
  localparam logic [7:0]  REG_CTRL   = 8'h28;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/conv_mac.sv
// Signed multiply-accumulate: stage P registers the product, stage A accumulates.
// Latency: a valid pair reaches the accumulator two edges after vld_i.
// No backpressure; clr_i zeroes the sum, flush_i drops any in-flight product.
module conv_mac
  import ml_acc_pkg::*;
#(
  parameter int DATA_W = ml_acc_pkg::DATA_W,
  parameter int LEN_W  = ml_acc_pkg::LEN_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clr_i,
  input  logic              flush_i,
  input  logic              vld_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic [DATA_W-1:0] sat_o,
  output logic              clip_o
);

  localparam int ACC_L = calc_acc_w(DATA_W, LEN_W);
  localparam int PRD_W = 2 * DATA_W;

  // Clip bounds sign-extended into the accumulator width.
  localparam logic signed [ACC_L-1:0] HI_A = {{(ACC_L-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_L-1:0] LO_A = {{(ACC_L-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [PRD_W-1:0] p_q, p_d;
  logic                    p_vld_q, p_vld_d;
  logic signed [ACC_L-1:0] acc_q, acc_d;

  // Next-state for the product and accumulator stages.
  always_comb begin
    p_d     = p_q;
    p_vld_d = vld_i & ~flush_i & ~clr_i;
    acc_d   = acc_q;
    if (vld_i) begin
      p_d = $signed(a_i) * $signed(b_i);
    end
    if (clr_i) begin
      acc_d = '0;
    end else if (p_vld_q && !flush_i) begin
      acc_d = acc_q + $signed({{(ACC_L-PRD_W){p_q[PRD_W-1]}}, p_q});
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      p_q     <= '0;
      p_vld_q <= 1'b0;
      acc_q   <= '0;
    end else begin
      p_q     <= p_d;
      p_vld_q <= p_vld_d;
      acc_q   <= acc_d;
    end
  end

  // Saturate the running sum to the element range.
  always_comb begin
    sat_o  = acc_q[DATA_W-1:0];
    clip_o = 1'b0;
    if (acc_q > HI_A) begin
      sat_o  = HI_A[DATA_W-1:0];
      clip_o = 1'b1;
    end else if (acc_q < LO_A) begin
      sat_o  = LO_A[DATA_W-1:0];
      clip_o = 1'b1;
    end
  end

  assign busy_o = p_vld_q;

endmodule

// File: rtl/conv_seq_ctrl.sv
// Sequences N BRAM pair reads into a saturating MAC and publishes result/status.
// Latency: done_pulse N+RD_LAT+3 cycles after launch (1 cycle when N==0).
// No backpressure: BRAMs answer in fixed RD_LAT; start edges outside IDLE are dropped.
module conv_seq_ctrl
  import ml_acc_pkg::*;
#(
  parameter int DATA_W = ml_acc_pkg::DATA_W,
  parameter int LEN_W  = ml_acc_pkg::LEN_W,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              start_lvl,
  input  logic              abort,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] w_addr,
  output logic              w_en,
  input  logic [DATA_W-1:0] w_dout,
  output logic [ADDR_W-1:0] x_addr,
  output logic              x_en,
  input  logic [DATA_W-1:0] x_dout,
  output logic [DATA_W-1:0] result,
  output logic              ovf,
  output logic              busy,
  output logic              done,
  output logic              done_pulse
);

  state_t             state_q, state_d;
  logic               start_prev_q;
  logic [LEN_W-1:0]   idx_q, len_q;
  logic [RD_LAT-1:0]  vsr_q, vsr_d;
  logic               busy_q, done_q, ovf_q;
  logic [DATA_W-1:0]  result_q;

  logic               launch, issue, last_issue, fin, pipe_empty;
  logic [ADDR_W-1:0]  addr;
  logic               mac_busy, mac_clip;
  logic [DATA_W-1:0]  mac_sat;

  assign launch     = (state_q == IDLE) && start_lvl && !start_prev_q && !abort;
  assign issue      = (state_q == ISSUE);
  assign last_issue = (idx_q == len_q - LEN_W'(1));
  assign fin        = (state_q == FIN) && !abort;
  assign pipe_empty = (vsr_q == '0) && !mac_busy;
  assign addr       = ADDR_W'({idx_q, 2'b00});

  // Next state and the BRAM/pulse outputs decoded from the current state.
  always_comb begin
    state_d    = state_q;
    w_en       = 1'b0;
    x_en       = 1'b0;
    w_addr     = '0;
    x_addr     = '0;
    done_pulse = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (launch) begin
          state_d = (len == '0) ? FIN : ISSUE;
        end
      end
      ISSUE: begin
        w_en   = 1'b1;
        x_en   = 1'b1;
        w_addr = addr;
        x_addr = addr;
        if (last_issue) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pipe_empty) begin
          state_d = FIN;
        end
      end
      FIN: begin
        done_pulse = !abort;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
    end
  end

  // Shift the issue strobe along so it lines up with returning BRAM data.
  always_comb begin
    vsr_d    = vsr_q << 1;
    vsr_d[0] = issue;
  end

  // State register and start-level history; history runs in every state so
  // an edge seen while busy is consumed rather than queued.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_lvl;
    end
  end

  // Element count capture and read index.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      len_q <= '0;
      idx_q <= '0;
    end else if (launch) begin
      len_q <= len;
      idx_q <= '0;
    end else if (issue) begin
      idx_q <= idx_q + LEN_W'(1);
    end
  end

  // Read-valid tags; abort drops anything still in flight.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      vsr_q <= '0;
    end else if (abort) begin
      vsr_q <= '0;
    end else begin
      vsr_q <= vsr_d;
    end
  end

  // Status and result registers visible to the PS.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else if (abort) begin
      busy_q <= 1'b0;
    end else if (launch) begin
      busy_q <= 1'b1;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (fin) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b1;
      ovf_q    <= mac_clip;
      result_q <= mac_sat;
    end
  end

  conv_mac #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) u_mac (
    .clk_i   (ACLK),
    .rst_n_i (ARESETn),
    .clr_i   (launch),
    .flush_i (abort),
    .vld_i   (vsr_q[RD_LAT-1]),
    .a_i     (w_dout),
    .b_i     (x_dout),
    .busy_o  (mac_busy),
    .sat_o   (mac_sat),
    .clip_o  (mac_clip)
  );

  assign result = result_q;
  assign ovf    = ovf_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
